// File: rtl/camera_capture_ctrl_pkg.sv
// camera_pkg: shared types and default widths for the camera capture
// sequencer. Ports: none (package only).
package camera_pkg;

    localparam int PIX_W_DEF = 20;
    localparam int TMO_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/camera_capture_ctrl_if.sv
// Command, config, sensor-tap and status bundle for camera_capture_ctrl.
// slave: sequencer side; master: controller/sensor side.
interface camera_capture_ctrl_if #(
    parameter int PIX_W = camera_pkg::PIX_W_DEF,
    parameter int TMO_W = camera_pkg::TMO_W_DEF
);
    logic             cmd_start;
    logic             cmd_stop;
    logic [7:0]       cfg_num_frames;
    logic [PIX_W-1:0] cfg_frame_pixels;
    logic [TMO_W-1:0] cfg_timeout;
    logic             cam_valid;
    logic             cam_sof;
    logic             cap_enable;
    logic             busy;
    logic             done;
    logic [15:0]      frames_done;
    logic             err_short;
    logic             err_long;
    logic             err_timeout;

    modport slave (
        input  cmd_start, cmd_stop,
        input  cfg_num_frames, cfg_frame_pixels, cfg_timeout,
        input  cam_valid, cam_sof,
        output cap_enable, busy, done, frames_done,
        output err_short, err_long, err_timeout
    );

    modport master (
        output cmd_start, cmd_stop,
        output cfg_num_frames, cfg_frame_pixels, cfg_timeout,
        output cam_valid, cam_sof,
        input  cap_enable, busy, done, frames_done,
        input  err_short, err_long, err_timeout
    );
endinterface

// File: rtl/camera_watchdog.sv
// Stall watchdog: counts run cycles without clear; pulses expire at limit.
// Ports: clk, rst_n, clear, run, limit (0 = off), expire.
module camera_watchdog #(
    parameter int TMO_W = camera_pkg::TMO_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic [TMO_W-1:0] limit,
    output logic             expire
);
    localparam logic [TMO_W-1:0] ONE = 1;

    logic [TMO_W-1:0] cnt;

    // cnt holds the idle cycles already elapsed, so the cycle that
    // would make it reach limit is the expiring one.
    assign expire = run && !clear && (limit != '0)
                    && (cnt == limit - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || clear || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end
endmodule

// File: rtl/camera_capture_ctrl.sv
// Frame-aligned capture sequencer: gates cap_enable to whole frames.
// Ports: clk, rst_n, bus (camera_capture_ctrl_if.slave).
module camera_capture_ctrl
    import camera_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int TMO_W = TMO_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    camera_capture_ctrl_if.slave  bus
);
    localparam logic [PIX_W-1:0] PIX_ONE = 1;

    cap_state_e       state_q, state_d;
    logic             in_frame_q, in_frame_d;
    logic             stop_q, stop_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [15:0]      frames_q, frames_d;
    logic             e_short_q, e_short_d;
    logic             e_long_q, e_long_d;
    logic             e_tmo_q, e_tmo_d;
    logic             done_q, done_d;
    logic [7:0]       num_q, num_d;
    logic [PIX_W-1:0] fpix_q, fpix_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic sof;
    logic accept;
    logic cap_en;
    logic expire;
    logic start_acc;

    assign sof       = bus.cam_valid && bus.cam_sof;
    assign start_acc = bus.cmd_start && (state_q == IDLE);

    camera_watchdog #(.TMO_W(TMO_W)) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (bus.cam_valid || start_acc),
        .run    (state_q != IDLE),
        .limit  (tmo_q),
        .expire (expire)
    );

    always_comb begin
        state_d    = state_q;
        in_frame_d = in_frame_q;
        stop_d     = stop_q;
        pix_d      = pix_q;
        frames_d   = frames_q;
        e_short_d  = e_short_q;
        e_long_d   = e_long_q;
        e_tmo_d    = e_tmo_q;
        num_d      = num_q;
        fpix_d     = fpix_q;
        tmo_d      = tmo_q;
        accept     = 1'b0;
        cap_en     = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_start) begin
                    state_d    = ARMED;
                    in_frame_d = 1'b0;
                    stop_d     = 1'b0;
                    pix_d      = '0;
                    frames_d   = '0;
                    e_short_d  = 1'b0;
                    e_long_d   = 1'b0;
                    e_tmo_d    = 1'b0;
                    num_d      = bus.cfg_num_frames;
                    fpix_d     = bus.cfg_frame_pixels;
                    tmo_d      = bus.cfg_timeout;
                end
            end
            ARMED: begin
                cap_en = sof;
                if (expire) begin
                    state_d = IDLE;
                    e_tmo_d = 1'b1;
                end else if (bus.cmd_stop) begin
                    state_d  = IDLE;
                    frames_d = '0;
                end else if (sof) begin
                    state_d    = CAPTURE;
                    in_frame_d = 1'b1;
                    pix_d      = PIX_ONE;
                    accept     = 1'b1;
                end
            end
            CAPTURE: begin
                cap_en = in_frame_q || sof;
                if (expire) begin
                    // partial frame is dropped, not counted
                    state_d    = IDLE;
                    e_tmo_d    = 1'b1;
                    in_frame_d = 1'b0;
                    pix_d      = '0;
                end else if (bus.cmd_stop && !in_frame_q) begin
                    state_d = IDLE;
                end else begin
                    if (bus.cmd_stop) stop_d = 1'b1;
                    if (sof) begin
                        if (in_frame_q) e_short_d = 1'b1;
                        in_frame_d = 1'b1;
                        pix_d      = PIX_ONE;
                        accept     = 1'b1;
                    end else if (bus.cam_valid) begin
                        if (in_frame_q) begin
                            pix_d  = pix_q + PIX_ONE;
                            accept = 1'b1;
                        end else begin
                            e_long_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // a counted beat that lands on the configured length closes
        // the frame; with length 1 the SOF beat opens and closes it
        if (accept && (pix_d == fpix_q)) begin
            frames_d   = frames_q + 16'd1;
            in_frame_d = 1'b0;
            pix_d      = '0;
            if (((num_q != 8'd0) && (frames_d == {8'd0, num_q}))
                || stop_d) begin
                state_d = IDLE;
            end
        end

        done_d = (state_q != IDLE) && (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_frame_q <= 1'b0;
            stop_q     <= 1'b0;
            pix_q      <= '0;
            frames_q   <= '0;
            e_short_q  <= 1'b0;
            e_long_q   <= 1'b0;
            e_tmo_q    <= 1'b0;
            done_q     <= 1'b0;
            num_q      <= '0;
            fpix_q     <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_frame_q <= in_frame_d;
            stop_q     <= stop_d;
            pix_q      <= pix_d;
            frames_q   <= frames_d;
            e_short_q  <= e_short_d;
            e_long_q   <= e_long_d;
            e_tmo_q    <= e_tmo_d;
            done_q     <= done_d;
            num_q      <= num_d;
            fpix_q     <= fpix_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.cap_enable  = cap_en;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.frames_done = frames_q;
    assign bus.err_short   = e_short_q;
    assign bus.err_long    = e_long_q;
    assign bus.err_timeout = e_tmo_q;
endmodule
